// File: rtl/outerprodrc_ctrl.sv
// Outer-product tile controller.
// Accepts operand blocks, drives the unary array through clear / run phases,
// waits for the array sum to settle at the end of a tile, then streams the
// result tile out one element at a time with a valid/ready handshake.
module outerprodrc_ctrl #(
   parameter int ROWNUM      = 2,
   parameter int COLNUM      = 2,
   parameter int HIDDEN      = 1,
   parameter int BITWIDTH    = 4,
   parameter int OUTBITWIDTH = 5,
   parameter int CYCLES      = 16,
   parameter int LAT         = 1
) (
   input  logic                                     iClk,
   input  logic                                     iRst,
   input  logic                                     iOpValid,
   output logic                                     oOpReady,
   input  logic                                     iOpLast,
   input  logic [HIDDEN*ROWNUM*BITWIDTH-1:0]        iOpData0,
   input  logic [HIDDEN*COLNUM*BITWIDTH-1:0]        iOpData1,
   output logic                                     oEn,
   output logic                                     oClr,
   output logic [HIDDEN*ROWNUM*BITWIDTH-1:0]        oData0,
   output logic [HIDDEN*COLNUM*BITWIDTH-1:0]        oData1,
   input  logic [ROWNUM*COLNUM*2*OUTBITWIDTH-1:0]   iSum,
   output logic                                     oResValid,
   input  logic                                     iResReady,
   output logic [2*OUTBITWIDTH-1:0]                 oResData,
   output logic                                     oResLast
);

   localparam int NUMEL = ROWNUM * COLNUM;
   localparam int EW    = 2 * OUTBITWIDTH;
   localparam int CW    = $clog2(CYCLES + 1);
   localparam int WW    = (LAT > 0) ? $clog2(LAT + 1) : 1;
   localparam int IW    = (NUMEL > 1) ? $clog2(NUMEL) : 1;

   localparam logic [CW-1:0] CYC_LAST  = CW'(CYCLES - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'((LAT > 0) ? (LAT - 1) : 0);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUMEL - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      RUN,
      WAIT,
      CAP,
      DRAIN
   } stateType;

   stateType          state;
   stateType          nextState;
   logic              tileStart;
   logic              lastFlag;
   logic [CW-1:0]     cycCnt;
   logic [WW-1:0]     waitCnt;
   logic [IW-1:0]     elemIdx;
   logic [EW-1:0]     resBuf [NUMEL];
   logic              accept;
   logic              runDone;
   logic              waitDone;
   logic              drainDone;

   // Handshake qualifiers derived from registered state; ready is withheld
   // while reset is held so no block can slip in during the reset cycle.
   always_comb begin
      oOpReady  = (state == IDLE) && !iRst;
      accept    = iOpValid && oOpReady;
      runDone   = (cycCnt == CYC_LAST);
      waitDone  = (waitCnt == WAIT_LAST);
      drainDone = iResReady && (elemIdx == IDX_LAST);
   end

   // State register; reset abandons whatever phase is in progress.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode: the clear phase only precedes the first block of a
   // tile, and the settle/capture/drain path only follows the last block.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (accept) begin
               nextState = tileStart ? CLR : RUN;
            end
         end
         CLR: begin
            nextState = RUN;
         end
         RUN: begin
            if (runDone) begin
               if (!lastFlag) begin
                  nextState = IDLE;
               end else if (LAT == 0) begin
                  nextState = CAP;
               end else begin
                  nextState = WAIT;
               end
            end
         end
         WAIT: begin
            if (waitDone) begin
               nextState = CAP;
            end
         end
         CAP: begin
            nextState = DRAIN;
         end
         DRAIN: begin
            if (drainDone) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Datapath registers: operand latch, tile bookkeeping, phase counters and
   // the result buffer. Counters return to zero on their terminal value so
   // they never run past the last legal count.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         tileStart <= 1'b1;
         lastFlag  <= 1'b0;
         cycCnt    <= '0;
         waitCnt   <= '0;
         elemIdx   <= '0;
         oData0    <= '0;
         oData1    <= '0;
         for (int e = 0; e < NUMEL; e++) begin
            resBuf[e] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  oData0   <= iOpData0;
                  oData1   <= iOpData1;
                  lastFlag <= iOpLast;
               end
            end
            CLR: begin
               tileStart <= 1'b0;
            end
            RUN: begin
               if (runDone) begin
                  cycCnt <= '0;
               end else begin
                  cycCnt <= cycCnt + 1'b1;
               end
            end
            WAIT: begin
               if (waitDone) begin
                  waitCnt <= '0;
               end else begin
                  waitCnt <= waitCnt + 1'b1;
               end
            end
            CAP: begin
               elemIdx <= '0;
               for (int e = 0; e < NUMEL; e++) begin
                  resBuf[e] <= iSum[e*EW +: EW];
               end
            end
            DRAIN: begin
               if (iResReady) begin
                  if (elemIdx == IDX_LAST) begin
                     elemIdx   <= '0;
                     tileStart <= 1'b1;
                  end else begin
                     elemIdx <= elemIdx + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Array controls and result stream are pure decodes of registered state,
   // so a stalled result stays put until the element index moves.
   always_comb begin
      oEn       = (state == RUN);
      oClr      = (state == CLR);
      oResValid = (state == DRAIN);
      oResLast  = (state == DRAIN) && (elemIdx == IDX_LAST);
      oResData  = '0;
      if (state == DRAIN) begin
         oResData = resBuf[elemIdx];
      end
   end

endmodule

// File: tb/tb_outerprodrc_ctrl.sv
// Testbench for outerprodrc_ctrl: default instance exercised through a
// result scoreboard, plus a CYCLES=1 / LAT=0 instance for the short path.
module tb_outerprodrc_ctrl;

   localparam int EW    = 10;
   localparam int NUMEL = 4;

   logic             iClk = 1'b0;
   logic             iRst;
   logic             iOpValid;
   logic             oOpReady;
   logic             iOpLast;
   logic [7:0]       iOpData0;
   logic [7:0]       iOpData1;
   logic             oEn;
   logic             oClr;
   logic [7:0]       oData0;
   logic [7:0]       oData1;
   logic [39:0]      iSum;
   logic             oResValid;
   logic             iResReady;
   logic [EW-1:0]    oResData;
   logic             oResLast;

   logic             bOpValid;
   logic             bOpReady;
   logic             bOpLast;
   logic [7:0]       bOpData0;
   logic [7:0]       bOpData1;
   logic             bEn;
   logic             bClr;
   logic [7:0]       bData0;
   logic [7:0]       bData1;
   logic             bResValid;
   logic             bResReady;
   logic [EW-1:0]    bResData;
   logic             bResLast;

   typedef struct {
      logic [EW-1:0] data;
      logic          last;
   } expType;

   expType         expQ[$];
   int             checkCount = 0;
   int             errorCount = 0;
   int             enCount    = 0;
   int             clrCount   = 0;
   int             drainCount = 0;
   int             holdChecks = 0;
   logic           prevStall  = 1'b0;
   logic [EW-1:0]  prevData   = '0;
   logic           prevLast   = 1'b0;

   always #5 iClk = ~iClk;

   outerprodrc_ctrl dut (
      .iClk(iClk), .iRst(iRst),
      .iOpValid(iOpValid), .oOpReady(oOpReady), .iOpLast(iOpLast),
      .iOpData0(iOpData0), .iOpData1(iOpData1),
      .oEn(oEn), .oClr(oClr), .oData0(oData0), .oData1(oData1),
      .iSum(iSum),
      .oResValid(oResValid), .iResReady(iResReady),
      .oResData(oResData), .oResLast(oResLast)
   );

   outerprodrc_ctrl #(.CYCLES(1), .LAT(0)) dutShort (
      .iClk(iClk), .iRst(iRst),
      .iOpValid(bOpValid), .oOpReady(bOpReady), .iOpLast(bOpLast),
      .iOpData0(bOpData0), .iOpData1(bOpData1),
      .oEn(bEn), .oClr(bClr), .oData0(bData0), .oData1(bData1),
      .iSum(iSum),
      .oResValid(bResValid), .iResReady(bResReady),
      .oResData(bResData), .oResLast(bResLast)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Result monitor: scoreboard pops on each handshake, stall stability,
   // enable/clear bookkeeping.
   always @(negedge iClk) begin : monitor
      expType e;
      if (iRst) begin
         prevStall = 1'b0;
      end else begin
         if (oEn) enCount++;
         if (oClr) clrCount++;
         if (oEn && oClr) checkOutput("enClrOverlap", 1, 0);
         if (prevStall) begin
            holdChecks++;
            checkOutput("holdValid", oResValid, 1);
            checkOutput("holdData", oResData, prevData);
            checkOutput("holdLast", oResLast, prevLast);
         end
         if (oResValid && iResReady) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedResult", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("resData", oResData, e.data);
               checkOutput("resLast", oResLast, e.last);
            end
            if (oResLast) drainCount++;
         end
         prevStall = oResValid && !iResReady;
         prevData  = oResData;
         prevLast  = oResLast;
      end
   end

   // Offer one block and hold it until accepted; a tile-ending block queues
   // the result lanes the array currently presents.
   task automatic applyStimulus(input logic [7:0] d0, input logic [7:0] d1,
                                input logic last);
      expType e;
      int guard = 0;
      iOpData0 = d0;
      iOpData1 = d1;
      iOpLast  = last;
      iOpValid = 1'b1;
      @(negedge iClk);
      while (!oOpReady && guard < 500) begin
         @(negedge iClk);
         guard++;
      end
      if (guard >= 500) checkOutput("acceptTimeout", 0, 1);
      if (last) begin
         for (int i = 0; i < NUMEL; i++) begin
            e.data = iSum[i*EW +: EW];
            e.last = (i == NUMEL - 1);
            expQ.push_back(e);
         end
      end
      @(posedge iClk);
      #1;
      iOpValid = 1'b0;
   endtask

   // Cycle map of the phases following an acceptance (cycle 0 = first
   // cycle after the accepting edge).
   task automatic traceBlock(input string tag, input int clrExp, input int enFirstExp,
                             input int enLastExp, input int validExp);
      int clrFirst = -1;
      int clrN = 0;
      int enFirst = -1;
      int enLast = -1;
      int enN = 0;
      int vFirst = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge iClk);
         if (oClr) begin
            if (clrFirst < 0) clrFirst = c;
            clrN++;
         end
         if (oEn) begin
            if (enFirst < 0) enFirst = c;
            enLast = c;
            enN++;
         end
         if (oResValid && vFirst < 0) vFirst = c;
      end
      checkOutput({tag, "ClrAt"}, clrFirst, clrExp);
      checkOutput({tag, "ClrLen"}, clrN, 1);
      checkOutput({tag, "EnFirst"}, enFirst, enFirstExp);
      checkOutput({tag, "EnLast"}, enLast, enLastExp);
      checkOutput({tag, "EnLen"}, enN, enLastExp - enFirstExp + 1);
      checkOutput({tag, "ValidAt"}, vFirst, validExp);
   endtask

   task automatic waitDrain(input int target);
      int guard = 0;
      while (drainCount < target && guard < 300) begin
         @(negedge iClk);
         guard++;
      end
      checkOutput("drainReached", drainCount, target);
      @(posedge iClk);
      #1;
   endtask

   // Global watchdog so the run always ends.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int enBase;
      int clrBase;
      int drainBase;
      int holdBase;
      int guard;
      int bad;
      logic sawDrain;
      expType e;

      iRst      = 1'b1;
      iOpValid  = 1'b0;
      iOpLast   = 1'b0;
      iOpData0  = '0;
      iOpData1  = '0;
      iResReady = 1'b1;
      iSum      = {10'd1000, 10'd513, 10'd77, 10'd300};
      bOpValid  = 1'b0;
      bOpLast   = 1'b1;
      bOpData0  = 8'h12;
      bOpData1  = 8'h34;
      bResReady = 1'b1;

      // Reset state
      repeat (2) @(posedge iClk);
      @(negedge iClk);
      checkOutput("rstReady", oOpReady, 0);
      checkOutput("rstEn", oEn, 0);
      checkOutput("rstClr", oClr, 0);
      checkOutput("rstValid", oResValid, 0);
      checkOutput("rstLast", oResLast, 0);
      checkOutput("rstResData", oResData, 0);
      checkOutput("rstData0", oData0, 0);
      checkOutput("rstData1", oData1, 0);
      @(posedge iClk);
      #1;
      iRst = 1'b0;
      @(negedge iClk);
      checkOutput("readyAfterReset", oOpReady, 1);
      @(posedge iClk);
      #1;

      // Single block tile
      $display("[TB] single block");
      enBase = enCount;
      applyStimulus(8'h3A, 8'hC5, 1'b1);
      checkOutput("latchData0", oData0, 8'h3A);
      checkOutput("latchData1", oData1, 8'hC5);
      traceBlock("single", 0, 1, 16, 19);
      waitDrain(1);
      checkOutput("singleEnTotal", enCount - enBase, 16);

      // Three-block tile
      $display("[TB] multi block");
      iSum      = {10'd5, 10'd1023, 10'd600, 10'd42};
      enBase    = enCount;
      clrBase   = clrCount;
      drainBase = drainCount;
      applyStimulus(8'h01, 8'h10, 1'b0);
      applyStimulus(8'h02, 8'h20, 1'b0);
      applyStimulus(8'h03, 8'h30, 1'b1);
      waitDrain(drainBase + 1);
      repeat (5) @(negedge iClk);
      checkOutput("multiEnTotal", enCount - enBase, 48);
      checkOutput("multiClrTotal", clrCount - clrBase, 1);
      checkOutput("multiDrains", drainCount - drainBase, 1);
      @(posedge iClk);
      #1;

      // Backpressure at element 2
      $display("[TB] backpressure");
      iSum      = {10'd11, 10'd222, 10'd333, 10'd444};
      drainBase = drainCount;
      applyStimulus(8'hAA, 8'h55, 1'b1);
      guard = 0;
      @(negedge iClk);
      while (!oResValid && guard < 100) begin
         @(negedge iClk);
         guard++;
      end
      checkOutput("bpValidSeen", oResValid, 1);
      @(posedge iClk);
      #1;
      @(posedge iClk);
      #1;
      iResReady = 1'b0;
      holdBase  = holdChecks;
      repeat (5) @(posedge iClk);
      #1;
      iResReady = 1'b1;
      waitDrain(drainBase + 1);
      checkOutput("bpHoldCycles", holdChecks - holdBase, 5);

      // Busy input held through RUN and DRAIN
      $display("[TB] busy input");
      iSum      = {10'd7, 10'd8, 10'd9, 10'd10};
      drainBase = drainCount;
      applyStimulus(8'h11, 8'h22, 1'b1);
      iOpData0 = 8'h77;
      iOpData1 = 8'h88;
      iOpLast  = 1'b1;
      iOpValid = 1'b1;
      bad      = 0;
      sawDrain = 1'b0;
      guard    = 0;
      while (guard < 500) begin
         @(negedge iClk);
         if (oOpReady) break;
         if (oResValid) sawDrain = 1'b1;
         if (oData0 !== 8'h11 || oData1 !== 8'h22) bad++;
         guard++;
      end
      checkOutput("busyDataHeld", bad, 0);
      checkOutput("busySawDrain", sawDrain, 1);
      checkOutput("busyReadyAgain", oOpReady, 1);
      for (int i = 0; i < NUMEL; i++) begin
         e.data = iSum[i*EW +: EW];
         e.last = (i == NUMEL - 1);
         expQ.push_back(e);
      end
      @(posedge iClk);
      #1;
      iOpValid = 1'b0;
      checkOutput("busyLatch0", oData0, 8'h77);
      checkOutput("busyLatch1", oData1, 8'h88);
      waitDrain(drainBase + 2);

      // Reset in the middle of RUN
      $display("[TB] reset mid-run");
      applyStimulus(8'h5C, 8'hA3, 1'b0);
      @(posedge iClk);
      #1;
      repeat (7) begin
         @(posedge iClk);
         #1;
      end
      checkOutput("midRunEn", oEn, 1);
      iRst = 1'b1;
      @(posedge iClk);
      #1;
      iRst = 1'b0;
      @(negedge iClk);
      checkOutput("postRstEn", oEn, 0);
      checkOutput("postRstReady", oOpReady, 1);
      @(posedge iClk);
      #1;
      drainBase = drainCount;
      iSum = {10'd900, 10'd800, 10'd700, 10'd600};
      applyStimulus(8'hE1, 8'h1E, 1'b1);
      traceBlock("afterRst", 0, 1, 16, 19);
      waitDrain(drainBase + 1);

      // CYCLES=1, LAT=0 instance
      $display("[TB] short instance");
      begin
         int enFirst = -1;
         int enN = 0;
         int clrN = 0;
         int vFirst = -1;
         logic [EW-1:0] firstData = '0;
         bOpValid = 1'b1;
         @(negedge iClk);
         checkOutput("shortReady", bOpReady, 1);
         @(posedge iClk);
         #1;
         bOpValid = 1'b0;
         for (int c = 0; c < 12; c++) begin
            @(negedge iClk);
            if (bClr) clrN++;
            if (bEn) begin
               if (enFirst < 0) enFirst = c;
               enN++;
            end
            if (bResValid && vFirst < 0) begin
               vFirst = c;
               firstData = bResData;
            end
         end
         checkOutput("shortClrLen", clrN, 1);
         checkOutput("shortEnFirst", enFirst, 1);
         checkOutput("shortEnLen", enN, 1);
         checkOutput("shortValidAt", vFirst, 3);
         checkOutput("shortFirstData", firstData, iSum[EW-1:0]);
      end

      repeat (5) @(negedge iClk);
      checkOutput("queueEmpty", expQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/outerprodrc_ctrl.md
OUTERPRODRC_CTRL -- requirements
Module: outerprodrc_ctrl

Interface
REQ-001 Parameter ROWNUM, default 2: rows in the result tile.
REQ-002 Parameter COLNUM, default 2: columns in the result tile.
REQ-003 Parameter HIDDEN, default 1: vector pairs per operand block.
REQ-004 Parameter BITWIDTH, default 4: operand element width.
REQ-005 Parameter OUTBITWIDTH, default 5: array per-lane width; each result element is 2*OUTBITWIDTH bits.
REQ-006 Parameter CYCLES, default 16: enabled unary cycles per block; legal range is 1 or more.
REQ-007 Parameter LAT, default 1: array sum latency after the last oEn cycle; legal range is 0 or more.
REQ-008 Reset and clock: one clock; reset is synchronous and active-high.
REQ-009 iClk  in  1  clock; all state updates on the rising edge.
REQ-010 iRst  in  1  synchronous active-high reset.
REQ-011 iOpValid  in  1  operand block is valid.
REQ-012 oOpReady  out  1  controller accepts an operand block.
REQ-013 iOpLast  in  1  the block is the last block of the current tile.
REQ-014 iOpData0  in  HIDDEN*ROWNUM*BITWIDTH  row operands.
REQ-015 iOpData1  in  HIDDEN*COLNUM*BITWIDTH  column operands.
REQ-016 oEn  out  1  array enable.
REQ-017 oClr  out  1  array accumulator clear.
REQ-018 oData0  out  HIDDEN*ROWNUM*BITWIDTH  latched row operands to the array.
REQ-019 oData1  out  HIDDEN*COLNUM*BITWIDTH  latched column operands to the array.
REQ-020 iSum  in  ROWNUM*COLNUM*2*OUTBITWIDTH  array result; element (r,c) is at offset (r*COLNUM+c)*2*OUTBITWIDTH.
REQ-021 oResValid  out  1  result element is valid.
REQ-022 iResReady  in  1  downstream accepts the result element.
REQ-023 oResData  out  2*OUTBITWIDTH  result element.
REQ-024 oResLast  out  1  asserted with the final element of the tile.

Function
REQ-025 The FSM states are IDLE, CLR, RUN, WAIT, CAP and DRAIN.
REQ-026 IDLE: oOpReady=1; acceptance occurs when iOpValid and oOpReady are both 1 on a rising edge.
REQ-027 On acceptance, the block latches iOpData0/1 into oData0/1 and iOpLast into lastFlag.
REQ-028 On acceptance in IDLE, the next state is CLR if tileStart=1, else RUN.
REQ-029 CLR: oClr=1 for exactly one cycle, then tileStart clears to 0 and the next state is RUN.
REQ-030 RUN: oEn=1 for exactly CYCLES consecutive cycles, counted 0..CYCLES-1.
REQ-031 On RUN exit, the next state is WAIT if lastFlag=1, else IDLE with accumulation preserved (no oClr).
REQ-032 WAIT: lasts LAT cycles with oEn=0; when LAT=0, RUN goes directly to CAP.
REQ-033 CAP: lasts one cycle; iSum is registered into the result buffer; the next state is DRAIN.
REQ-034 DRAIN: oResValid=1; elements are emitted row-major with index 0..ROWNUM*COLNUM-1.
REQ-035 DRAIN: the index advances only on oResValid and iResReady both 1.
REQ-036 DRAIN: oResLast=1 only at index ROWNUM*COLNUM-1.
REQ-037 On the final handshake, the next state is IDLE and tileStart is set to 1.
REQ-038 Backpressure: while iResReady=0, oResData, oResLast and oResValid are held stable.
REQ-039 oOpReady=0 in every state other than IDLE; iOpValid is ignored there and no operands are latched.
REQ-040 oData0/1 hold their value from acceptance until the next acceptance.
REQ-041 oEn and oClr are never asserted in the same cycle.
REQ-042 oEn=0 outside RUN and oClr=0 outside CLR.
REQ-043 The unary cycle counter is sized clog2(CYCLES+1) bits and never wraps past CYCLES-1.
REQ-044 The element index is sized to hold ROWNUM*COLNUM-1 and never wraps past ROWNUM*COLNUM-1.
REQ-045 All outputs are registered or decoded from registered state only; there is no combinational path from iOpValid or iResReady to any output.

Reset
REQ-046 iRst=1 forces IDLE and tileStart=1, and clears counters, lastFlag and the result buffer to 0.
REQ-047 iRst=1 drives oEn=0, oClr=0, oResValid=0, oResLast=0, oResData=0 and oData0/1=0.
REQ-048 oOpReady=0 during the reset cycle and 1 from the first cycle after reset deasserts.
REQ-049 Reset asserted in any state, including mid-RUN or mid-DRAIN, abandons the operation with no further oEn or result output; the next accepted block begins with CLR.

Verification
REQ-050 Single block: defaults, accept one block with iOpLast=1 -> oClr for 1 cycle, oEn for 16 cycles, 1 WAIT cycle, CAP, then 4 elements equal to iSum lanes 0..3, with oResLast on the 4th.
REQ-051 Multi-block tile: 3 blocks with iOpLast=0,0,1 -> oClr only before the first block, 48 total oEn cycles, and exactly one drain.
REQ-052 Backpressure: iResReady=0 for 5 cycles at index 2 -> oResData and oResValid stable throughout, no index skip, all 4 elements delivered in order.
REQ-053 Busy input: iOpValid=1 held during RUN and DRAIN -> oOpReady=0 and oData0/1 unchanged until IDLE; the block is then accepted.
REQ-054 Reset mid-RUN: iRst at counter 7 -> oEn=0 next cycle, and the next block shows a 1-cycle oClr followed by a full 16 oEn cycles.
REQ-055 Edge parameters: CYCLES=1, LAT=0 -> oEn is 1 cycle, then CAP immediately follows RUN.
